// File: rtl/aes_scan_pkg.sv
// Shared types and defaults for the AES state scan chain.
package aes_scan_pkg;

   localparam int unsigned DEFAULT_CHAIN_LEN = 128;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      SHIFT   = 3'd2,
      UPDATE  = 3'd3,
      DONE    = 3'd4
   } scan_state_t;

endpackage

// File: rtl/aes_scan_chain_if.sv
// Bundle between the secure-scan test controller / AES core and the scan engine.
interface aes_scan_chain_if #(
   parameter int unsigned CHAIN_LEN = aes_scan_pkg::DEFAULT_CHAIN_LEN
);

   logic                 scan_mode;
   logic                 enable_scan_in;
   logic                 enable_scan_out;
   logic                 loadkey;
   logic                 scan_start;
   logic                 scan_si;
   logic [CHAIN_LEN-1:0] capture_data;
   logic                 scan_so;
   logic [CHAIN_LEN-1:0] shift_data;
   logic                 shift_load;
   logic                 scan_busy;
   logic                 scan_done;
   logic                 scan_abort;

   modport master (
      output scan_mode, enable_scan_in, enable_scan_out, loadkey, scan_start, scan_si,
             capture_data,
      input  scan_so, shift_data, shift_load, scan_busy, scan_done, scan_abort
   );

   modport slave (
      input  scan_mode, enable_scan_in, enable_scan_out, loadkey, scan_start, scan_si,
             capture_data,
      output scan_so, shift_data, shift_load, scan_busy, scan_done, scan_abort
   );

endinterface

// File: rtl/scan_shift_reg.sv
// CHAIN_LEN-bit scan register: parallel capture, LSB-first shift, clear wins.
module scan_shift_reg #(
   parameter int unsigned CHAIN_LEN = aes_scan_pkg::DEFAULT_CHAIN_LEN
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 capture_i,
   input  logic                 shift_i,
   input  logic                 clear_i,
   input  logic                 si_i,
   input  logic [CHAIN_LEN-1:0] data_i,
   output logic                 so_o,
   output logic [CHAIN_LEN-1:0] chain_o
);

   logic [CHAIN_LEN-1:0] chain_q, chain_d;

   always_comb begin
      chain_d = chain_q;
      if (clear_i) begin
         chain_d = '0;
      end else if (capture_i) begin
         chain_d = data_i;
      end else if (shift_i) begin
         chain_d = {si_i, chain_q[CHAIN_LEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign so_o    = chain_q[0];
   assign chain_o = chain_q;

endmodule

// File: rtl/aes_scan_chain.sv
// Scan engine for the AES state: capture, serial shift, one-cycle parallel update.
module aes_scan_chain #(
   parameter int unsigned CHAIN_LEN = aes_scan_pkg::DEFAULT_CHAIN_LEN
) (
   input  logic             clk,
   input  logic             reset_n,
   aes_scan_chain_if.slave  bus
);
   import aes_scan_pkg::*;

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN);

   localparam logic [2:0] S_IDLE    = 3'(IDLE);
   localparam logic [2:0] S_CAPTURE = 3'(CAPTURE);
   localparam logic [2:0] S_SHIFT   = 3'(SHIFT);
   localparam logic [2:0] S_UPDATE  = 3'(UPDATE);
   localparam logic [2:0] S_DONE    = 3'(DONE);

   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 abort_q, abort_d;
   logic                 lock_c;
   logic                 capture_c;
   logic                 shift_c;
   logic                 clear_c;
   logic                 si_g_c;
   logic                 chain_so;
   logic [CHAIN_LEN-1:0] chain;

   assign lock_c = bus.loadkey | ~bus.scan_mode;
   assign si_g_c = bus.scan_si & bus.enable_scan_in;

   // Next-state; a lock during CAPTURE/SHIFT/UPDATE overrides every normal transition.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      abort_d   = 1'b0;
      capture_c = 1'b0;
      shift_c   = 1'b0;
      clear_c   = bus.loadkey;

      if (lock_c && (state_q == S_CAPTURE || state_q == S_SHIFT || state_q == S_UPDATE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         abort_d = 1'b1;
         clear_c = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.scan_start && !lock_c) begin
                  state_d = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               capture_c = 1'b1;
               cnt_d     = '0;
               state_d   = S_SHIFT;
            end
            S_SHIFT: begin
               shift_c = 1'b1;
               if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                  cnt_d   = '0;
                  state_d = S_UPDATE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_UPDATE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   scan_shift_reg #(.CHAIN_LEN(CHAIN_LEN)) u_chain (
      .clk       (clk),
      .reset_n   (reset_n),
      .capture_i (capture_c),
      .shift_i   (shift_c),
      .clear_i   (clear_c),
      .si_i      (si_g_c),
      .data_i    (bus.capture_data),
      .so_o      (chain_so),
      .chain_o   (chain)
   );

   // Output decode from registered state only (plus the scan-out gate).
   assign bus.scan_so    = (state_q == S_SHIFT) & chain_so & bus.enable_scan_out;
   assign bus.shift_data = chain;
   assign bus.shift_load = (state_q == S_UPDATE);
   assign bus.scan_busy  = (state_q != S_IDLE);
   assign bus.scan_done  = (state_q == S_DONE);
   assign bus.scan_abort = abort_q;

endmodule

// File: tb/tb_aes_scan_chain.sv
// Scoreboard bench for aes_scan_chain: scan-out stream, round trip, abort, blocking, gating.
module tb_aes_scan_chain;
   import aes_scan_pkg::*;

   localparam int unsigned N    = DEFAULT_CHAIN_LEN;
   localparam int          LAST = N + 4;

   logic clk = 1'b0;
   logic reset_n;

   aes_scan_chain_if #(.CHAIN_LEN(N)) bus ();

   aes_scan_chain #(.CHAIN_LEN(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic         so_a    [0:LAST];
   logic         load_a  [0:LAST];
   logic         done_a  [0:LAST];
   logic         busy_a  [0:LAST];
   logic         abort_a [0:LAST];
   logic [N-1:0] sd_a    [0:LAST];
   bit           exp_q   [$];

   function automatic logic [N-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Cycle c is the c-th cycle after the edge that samples scan_start.
   task automatic run_scan(input logic [N-1:0] cap, input logic [N-1:0] si,
                           input logic en_in, input logic en_out, input int abort_c);
      bus.scan_mode       = 1'b1;
      bus.loadkey         = 1'b0;
      bus.enable_scan_in  = en_in;
      bus.enable_scan_out = en_out;
      bus.capture_data    = cap;
      bus.scan_si         = 1'b0;
      bus.scan_start      = 1'b1;
      for (int c = 1; c <= LAST; c++) begin
         @(negedge clk);
         bus.scan_start = 1'b0;
         so_a[c]    = bus.scan_so;
         load_a[c]  = bus.shift_load;
         done_a[c]  = bus.scan_done;
         busy_a[c]  = bus.scan_busy;
         abort_a[c] = bus.scan_abort;
         sd_a[c]    = bus.shift_data;
         bus.scan_si = (c >= 2 && c <= N + 1) ? si[c-2] : 1'b0;
         if (abort_c != 0 && c == abort_c) bus.loadkey = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_n             = 1'b0;
      bus.scan_start      = 1'b1;
      bus.scan_mode       = 1'b1;
      bus.enable_scan_in  = 1'b1;
      bus.enable_scan_out = 1'b1;
      bus.loadkey         = 1'b0;
      bus.scan_si         = 1'b1;
      bus.capture_data    = '1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.scan_so, bus.shift_load, bus.scan_busy, bus.scan_done, bus.scan_abort} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs cycle %0d: got %b expected 00000", i,
                     {bus.scan_so, bus.shift_load, bus.scan_busy, bus.scan_done, bus.scan_abort});
         end
         vectors++;
         if (bus.shift_data !== '0) begin
            miscompares++;
            $display("FAIL reset_chain cycle %0d: got %h expected 0", i, bus.shift_data);
         end
      end
      bus.scan_start = 1'b0;
      reset_n        = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.scan_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_busy: got %b expected 0", bus.scan_busy);
      end
   endtask

   task automatic test_shift_out();
      logic [N-1:0] cap;
      bit           e;
      cap = 128'h0123456789ABCDEF_FEDCBA9876543210;
      for (int i = 0; i < int'(N); i++) exp_q.push_back(cap[i]);
      run_scan(cap, rnd128(), 1'b1, 1'b1, 0);
      vectors++;
      if (so_a[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL shift_out_capture_so: got %b expected 0", so_a[1]);
      end
      for (int c = 2; c <= int'(N) + 1; c++) begin
         e = exp_q.pop_front();
         vectors++;
         if (so_a[c] !== e) begin
            miscompares++;
            $display("FAIL shift_out_bit%0d: got %b expected %b", c - 2, so_a[c], e);
         end
      end
      vectors++;
      if (so_a[N+2] !== 1'b0) begin
         miscompares++;
         $display("FAIL shift_out_update_so: got %b expected 0", so_a[N+2]);
      end
   endtask

   task automatic test_round_trip();
      logic [N-1:0] si;
      int loads, dones;
      si = {16{8'hA5}};
      run_scan(rnd128(), si, 1'b1, 1'b1, 0);
      loads = 0;
      dones = 0;
      for (int c = 1; c <= LAST; c++) begin
         loads += int'(load_a[c]);
         dones += int'(done_a[c]);
      end
      vectors++;
      if (loads != 1 || load_a[N+2] !== 1'b1) begin
         miscompares++;
         $display("FAIL round_trip_load: got %0d pulses (at 130: %b) expected 1 at 130", loads, load_a[N+2]);
      end
      vectors++;
      if (sd_a[N+2] !== si) begin
         miscompares++;
         $display("FAIL round_trip_data: got %h expected %h", sd_a[N+2], si);
      end
      vectors++;
      if (dones != 1 || done_a[N+3] !== 1'b1) begin
         miscompares++;
         $display("FAIL round_trip_done: got %0d pulses (at 131: %b) expected 1 at 131", dones, done_a[N+3]);
      end
      vectors++;
      if ({busy_a[1], busy_a[N+3], busy_a[N+4]} !== 3'b110) begin
         miscompares++;
         $display("FAIL round_trip_busy: got %b expected 110", {busy_a[1], busy_a[N+3], busy_a[N+4]});
      end
   endtask

   task automatic test_blocked();
      for (int pass = 0; pass < 2; pass++) begin
         bus.scan_mode  = (pass == 0) ? 1'b0 : 1'b1;
         bus.loadkey    = (pass == 0) ? 1'b0 : 1'b1;
         bus.scan_start = 1'b1;
         for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.scan_start = 1'b0;
            vectors++;
            if ({bus.scan_busy, bus.shift_load, bus.scan_done, bus.scan_abort} !== 4'b0) begin
               miscompares++;
               $display("FAIL blocked_pass%0d_cycle%0d: got %b expected 0000", pass, c,
                        {bus.scan_busy, bus.shift_load, bus.scan_done, bus.scan_abort});
            end
            if (pass == 1) begin
               vectors++;
               if (bus.shift_data !== '0) begin
                  miscompares++;
                  $display("FAIL blocked_loadkey_chain cycle%0d: got %h expected 0", c, bus.shift_data);
               end
            end
         end
      end
      bus.loadkey = 1'b0;
   endtask

   task automatic test_abort();
      logic [N-1:0] cap;
      bit           e;
      int loads, dones, aborts;
      cap = rnd128() | 128'h1;
      for (int i = 0; i < 40; i++) exp_q.push_back(cap[i]);
      run_scan(cap, rnd128(), 1'b1, 1'b1, 41);
      for (int c = 2; c <= 41; c++) begin
         e = exp_q.pop_front();
         vectors++;
         if (so_a[c] !== e) begin
            miscompares++;
            $display("FAIL abort_prefix_bit%0d: got %b expected %b", c - 2, so_a[c], e);
         end
      end
      vectors++;
      if ({busy_a[42], abort_a[42], so_a[42]} !== 3'b010 || sd_a[42] !== '0) begin
         miscompares++;
         $display("FAIL abort_next_cycle: got busy/abort/so %b chain %h expected 010 chain 0",
                  {busy_a[42], abort_a[42], so_a[42]}, sd_a[42]);
      end
      loads = 0;
      dones = 0;
      aborts = 0;
      for (int c = 1; c <= LAST; c++) begin
         loads  += int'(load_a[c]);
         dones  += int'(done_a[c]);
         aborts += int'(abort_a[c]);
      end
      vectors++;
      if (loads != 0 || dones != 0 || aborts != 1) begin
         miscompares++;
         $display("FAIL abort_pulses: got load %0d done %0d abort %0d expected 0 0 1", loads, dones, aborts);
      end
      bus.loadkey = 1'b0;
   endtask

   task automatic test_gating();
      int ones;
      run_scan(rnd128() | 128'h1, '1, 1'b0, 1'b0, 0);
      ones = 0;
      for (int c = 1; c <= LAST; c++) ones += int'(so_a[c]);
      vectors++;
      if (ones != 0) begin
         miscompares++;
         $display("FAIL gating_so: got %0d ones expected 0", ones);
      end
      vectors++;
      if (load_a[N+2] !== 1'b1 || sd_a[N+2] !== '0) begin
         miscompares++;
         $display("FAIL gating_update: got load %b data %h expected load 1 data 0", load_a[N+2], sd_a[N+2]);
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] cap_b, si_a, si_b;
      bit           e;
      si_a  = rnd128();
      si_b  = rnd128();
      cap_b = rnd128();
      run_scan(rnd128(), si_a, 1'b1, 1'b1, 0);
      vectors++;
      if (sd_a[N+2] !== si_a || done_a[N+3] !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first: got data %h done %b expected data %h done 1", sd_a[N+2], done_a[N+3], si_a);
      end
      for (int i = 0; i < int'(N); i++) exp_q.push_back(cap_b[i]);
      run_scan(cap_b, si_b, 1'b1, 1'b1, 0);
      vectors++;
      if (busy_a[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second_start: got busy %b expected 1", busy_a[1]);
      end
      for (int c = 2; c <= int'(N) + 1; c++) begin
         e = exp_q.pop_front();
         vectors++;
         if (so_a[c] !== e) begin
            miscompares++;
            $display("FAIL b2b_so_bit%0d: got %b expected %b", c - 2, so_a[c], e);
         end
      end
      vectors++;
      if (load_a[N+2] !== 1'b1 || sd_a[N+2] !== si_b) begin
         miscompares++;
         $display("FAIL b2b_second_data: got load %b data %h expected load 1 data %h", load_a[N+2], sd_a[N+2], si_b);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_shift_out();
      test_round_trip();
      test_blocked();
      test_abort();
      test_gating();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/aes_scan_chain.md
# aes_scan_chain

Serial scan engine for the 128-bit AES state register, directly downstream of the secure-scan test controller. It consumes the controller's scan_mode, enableScanIn, enableScanOut and loadkey outputs. It captures the AES state, shifts it out serially while shifting new test data in, then hands the new data back to the AES core as a one-cycle parallel update. Once the controller has locked secure mode (loadkey high), the chain is held at zero and no scan operation can start or continue.

## Interface
- CHAIN_LEN, 128, scan chain length in bits (equals AES state width)
- CNT_W, $clog2(CHAIN_LEN), shift counter width (derived, not overridden)

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- scan_mode  in  1  scan permitted (from test controller)
- enable_scan_in  in  1  serial input gate (from test controller)
- enable_scan_out  in  1  serial output gate (from test controller)
- loadkey  in  1  secure lock (from test controller); forces abort and clear
- scan_start  in  1  single-cycle request to begin an operation
- scan_si  in  1  serial scan data in
- capture_data  in  CHAIN_LEN  AES state to be captured
- scan_so  out  1  serial scan data out, LSB first
- shift_data  out  CHAIN_LEN  chain contents presented for parallel update
- shift_load  out  1  one-cycle strobe: AES core loads shift_data
- scan_busy  out  1  high in every state except IDLE
- scan_done  out  1  one-cycle completion pulse
- scan_abort  out  1  one-cycle pulse when an operation is aborted

## Operation
- Blocking predicate: lock = loadkey | ~scan_mode.
- FSM states are IDLE, CAPTURE, SHIFT, UPDATE and DONE.
- IDLE: moves to CAPTURE when scan_start=1 and lock=0. Otherwise scan_start is ignored, with no pulse and no state change.
- CAPTURE, one cycle: chain <= capture_data; counter <= 0; next state is SHIFT.
- SHIFT, CHAIN_LEN cycles:
  - chain <= {si_g, chain[CHAIN_LEN-1:1]}, where si_g = scan_si & enable_scan_in.
  - The counter increments each cycle. When counter == CHAIN_LEN-1, the next state is UPDATE.
- UPDATE, one cycle: shift_load=1 with shift_data=chain; next state is DONE.
- DONE, one cycle: scan_done=1; next state is IDLE.
- scan_so = chain[0] & enable_scan_out when state==SHIFT, else 0. It is decoded combinationally from registers only, never from inputs other than enable_scan_out.
- shift_data is continuously equal to chain. It is meaningful only while shift_load=1.
- Abort: lock=1 in CAPTURE, SHIFT or UPDATE takes effect at the next edge:
  - state <= IDLE, chain <= 0, counter <= 0;
  - scan_abort is pulsed for one cycle, during the cycle after the abort edge;
  - shift_load is not asserted.
  - Abort has priority over every normal transition, including SHIFT→UPDATE on the final bit.
- Lock in DONE does not abort; scan_done still pulses.
- While loadkey=1 the chain register is held at 0 in every state.
- Counter arithmetic is unsigned CNT_W bits and never wraps in normal use. It is cleared in CAPTURE and on abort.

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, chain=0, counter=0. scan_so, shift_load, scan_busy, scan_done and scan_abort are all 0.
- Reset is synchronous and dominates every other input, including mid-operation.
- Cycle timeline, with edge 0 being the edge that samples scan_start:

  | Cycles after edge 0 | State / action |
  |---|---|
  | 1 | CAPTURE |
  | 2..CHAIN_LEN+1 | SHIFT (cycle 2 presents capture_data[0] on scan_so) |
  | CHAIN_LEN+2 | UPDATE, shift_load=1 |
  | CHAIN_LEN+3 | DONE, scan_done=1 |
  | CHAIN_LEN+4 | IDLE |

- Total: 131 cycles for CHAIN_LEN=128.
- scan_si is sampled on each SHIFT-state edge. The bit sampled in the first SHIFT cycle ends up in shift_data[0].
- scan_start arriving while scan_busy=1 is ignored; no queueing.
- Back-to-back operations are allowed: scan_start may be asserted in the first IDLE cycle after DONE.

## Structure
- The shared package aes_scan_pkg holds:
  - the state enum, scan_state_t (IDLE, CAPTURE, SHIFT, UPDATE, DONE);
  - the default CHAIN_LEN constant, 128.
- One sub-module is natural: scan_shift_reg, the CHAIN_LEN-bit register.
  - Its controls are capture, shift and clear (clear has priority), taking si_g in and driving bit 0 out.
  - The FSM, counter and output decode stay in aes_scan_chain.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with scan_start=1 and scan_mode=1 → all outputs 0, scan_busy=0 throughout.
- Shift-out: capture_data=128'h0123456789ABCDEF_FEDCBA9876543210, scan_mode=1, enables=1, loadkey=0, one scan_start pulse → scan_so over the 128 SHIFT cycles equals capture_data bits 0..127 in order. Bit 0 is 0, bit 4 is 1.
- Round trip: scan_si driven with 128'hA5A5…A5 LSB-first → shift_load pulses exactly once, at cycle 130 after the start edge, with shift_data=128'hA5A5…A5. scan_done pulses in the next cycle.
- Abort: loadkey rises in SHIFT cycle 40 → next cycle has state IDLE, chain=0, scan_abort=1 for one cycle and scan_so=0. shift_load and scan_done never assert.
- Blocked start: scan_start with scan_mode=0, then with loadkey=1 → scan_busy stays 0, no pulses, and shift_data stays 0 under loadkey.
- Gating: enable_scan_out=0 and enable_scan_in=0 during a full operation → scan_so constantly 0, and shift_data=0 at shift_load.
